// File: rtl/fht_pkg.sv
// Shared types and helpers for the FHT frame mover and its benches.
package fht_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_FETCH,
        ST_EMIT
    } t_mover_state;

    localparam int FHT_BANKS = 4;
    localparam int BANK_W    = $clog2(FHT_BANKS);

    // Reverses the low 'width' bits of 'value'; bits at and above 'width' come back as zero.
    function automatic logic [31:0] F_BIT_REV(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = value[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_row_serializer.sv
// Turns one captured row (BANKS parallel words) into a valid/ready word stream, bank 0 first.
module fht_row_serializer
    import fht_pkg::*;
#(
    parameter int D_BIT = 22,
    parameter int BANKS = 2**BANK_W
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iLOAD,
    input  logic [BANKS*D_BIT-1:0] iROW,
    input  logic                   iLAST_ROW,
    output logic [D_BIT-1:0]       oM_DATA,
    output logic                   oM_VALID,
    input  logic                   iM_READY,
    output logic                   oM_LAST,
    output logic                   oROW_DONE
);

    localparam int BW = $clog2(BANKS);

    logic [BANKS*D_BIT-1:0] row_q, row_d;
    logic [BW-1:0]          idx_q, idx_d;
    logic                   valid_q, valid_d;
    logic                   last_row_q, last_row_d;
    logic                   word_hs;
    logic                   at_end;

    assign word_hs = valid_q & iM_READY;
    assign at_end  = (idx_q == BW'(BANKS - 1));

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (latch).
    always_comb begin
        row_d      = row_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        last_row_d = last_row_q;
        if (iLOAD) begin
            row_d      = iROW;
            idx_d      = '0;
            valid_d    = 1'b1;
            last_row_d = iLAST_ROW;
        end else if (word_hs) begin
            if (at_end) valid_d = 1'b0;
            else        idx_d   = idx_q + BW'(1);
        end
    end

    // NOTE: the row register is a handful of flops, not a RAM, so it is reset to keep oM_DATA at zero.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            row_q      <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            last_row_q <= 1'b0;
        end else begin
            row_q      <= row_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            last_row_q <= last_row_d;
        end
    end

    assign oM_DATA   = row_q[int'(idx_q)*D_BIT +: D_BIT];
    assign oM_VALID  = valid_q;
    assign oM_LAST   = valid_q & at_end & last_row_q;
    assign oROW_DONE = word_hs & at_end;

endmodule

// File: rtl/fht_frame_mover.sv
// Streams ADC samples into the FHT RAM banks, kicks the transform, then drains the result row by row.
module fht_frame_mover
    import fht_pkg::*;
#(
    parameter int D_BIT     = 22,
    parameter int ADC_WIDTH = 14,
    parameter int A_BIT     = 8,
    parameter int BANKS     = 2**BANK_W,
    parameter int RD_LAT    = 2,
    parameter int REV_OUT   = 1
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic [ADC_WIDTH-1:0]   iS_DATA,
    input  logic                   iS_VALID,
    output logic                   oS_READY,
    output logic [BANKS-1:0]       oWE,
    output logic [A_BIT-1:0]       oADDR_WR,
    output logic [D_BIT-1:0]       oDATA_WR,
    output logic                   oSTART,
    input  logic                   iDONE,
    output logic [A_BIT-1:0]       oADDR_RD,
    input  logic [BANKS*D_BIT-1:0] iDATA_RD,
    output logic [D_BIT-1:0]       oM_DATA,
    output logic                   oM_VALID,
    input  logic                   iM_READY,
    output logic                   oM_LAST,
    output logic                   oBUSY
);

    localparam int BW   = $clog2(BANKS);
    localparam int K_W  = A_BIT + BW;
    localparam int PAD  = D_BIT - ADC_WIDTH;
    localparam int FC_W = $clog2(RD_LAT + 1);

    t_mover_state      state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [A_BIT-1:0]  row_q, row_d;
    logic [FC_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [BANKS-1:0]  we_q, we_d;
    logic [A_BIT-1:0]  addr_wr_q, addr_wr_d;
    logic [D_BIT-1:0]  data_wr_q, data_wr_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic [A_BIT-1:0]  addr_rd_q, addr_rd_d;
    logic [A_BIT-1:0]  row_inc;
    logic              capture;
    logic              row_done;

    function automatic logic [A_BIT-1:0] row_map(input logic [A_BIT-1:0] r);
        if (REV_OUT != 0) return A_BIT'(F_BIT_REV(32'(r), A_BIT));
        else              return r;
    endfunction

    assign row_inc = row_q + A_BIT'(1);
    assign capture = (state_q == ST_FETCH) && (fetch_cnt_q == FC_W'(RD_LAT));

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        fetch_cnt_d = fetch_cnt_q;
        we_d        = '0;
        addr_wr_d   = addr_wr_q;
        data_wr_d   = data_wr_q;
        start_d     = 1'b0;
        done_d      = iDONE;
        addr_rd_d   = addr_rd_q;
        case (state_q)
            ST_LOAD: begin
                if (iS_VALID) begin
                    we_d      = BANKS'(1) << k_q[BW-1:0];
                    addr_wr_d = k_q[K_W-1:BW];
                    data_wr_d = D_BIT'(iS_DATA) << PAD;
                    k_d       = k_q + K_W'(1);
                    if (&k_q) state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                start_d = 1'b1;
                // Pretend iDONE was already high so the previous frame's stale ready cannot look like a rise.
                done_d  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (iDONE && !done_q) begin
                    state_d     = ST_FETCH;
                    fetch_cnt_d = '0;
                    addr_rd_d   = row_map(row_q);
                end
            end
            ST_FETCH: begin
                if (capture) begin
                    state_d     = ST_EMIT;
                    fetch_cnt_d = '0;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + FC_W'(1);
                end
            end
            ST_EMIT: begin
                if (row_done) begin
                    row_d = row_inc;
                    if (&row_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d   = ST_FETCH;
                        addr_rd_d = row_map(row_inc);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q     <= ST_LOAD;
            k_q         <= '0;
            row_q       <= '0;
            fetch_cnt_q <= '0;
            we_q        <= '0;
            addr_wr_q   <= '0;
            data_wr_q   <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            addr_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            fetch_cnt_q <= fetch_cnt_d;
            we_q        <= we_d;
            addr_wr_q   <= addr_wr_d;
            data_wr_q   <= data_wr_d;
            start_q     <= start_d;
            done_q      <= done_d;
            addr_rd_q   <= addr_rd_d;
        end
    end

    fht_row_serializer #(
        .D_BIT (D_BIT),
        .BANKS (BANKS)
    ) u_serializer (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iLOAD     (capture),
        .iROW      (iDATA_RD),
        .iLAST_ROW (&row_q),
        .oM_DATA   (oM_DATA),
        .oM_VALID  (oM_VALID),
        .iM_READY  (iM_READY),
        .oM_LAST   (oM_LAST),
        .oROW_DONE (row_done)
    );

    assign oS_READY = (state_q == ST_LOAD);
    assign oBUSY    = (state_q != ST_LOAD);
    assign oWE      = we_q;
    assign oADDR_WR = addr_wr_q;
    assign oDATA_WR = data_wr_q;
    assign oSTART   = start_q;
    assign oADDR_RD = addr_rd_q;

endmodule

// File: tb/tb_fht_frame_mover.sv
// Bench for fht_frame_mover: a 4-bank bit-reversed instance and an 8-bank natural-order instance.
module tb_fht_frame_mover;

    localparam int D_BIT  = 22;
    localparam int ADC_W  = 14;
    localparam int RD_LAT = 2;
    localparam int N      = 32;
    localparam int B4 = 4, A4 = 3, R4 = 8;
    localparam int B8 = 8, A8 = 2, R8 = 4;

    typedef struct {
        logic [D_BIT-1:0] data;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ADC_W-1:0]    s_data4, s_data8;
    logic                s_valid4, s_valid8, s_ready4, s_ready8;
    logic [B4-1:0]       we4;
    logic [B8-1:0]       we8;
    logic [A4-1:0]       addr_wr4, addr_rd4;
    logic [A8-1:0]       addr_wr8, addr_rd8;
    logic [D_BIT-1:0]    data_wr4, data_wr8, m_data4, m_data8;
    logic                start4, start8, done4, done8;
    logic [B4*D_BIT-1:0] data_rd4;
    logic [B8*D_BIT-1:0] data_rd8;
    logic                m_valid4, m_valid8, m_ready4, m_ready8;
    logic                m_last4, m_last8, busy4, busy8;

    fht_frame_mover #(.D_BIT(D_BIT), .ADC_WIDTH(ADC_W), .A_BIT(A4), .BANKS(B4),
                      .RD_LAT(RD_LAT), .REV_OUT(1)) u_dut4 (
        .iCLK(clk), .iRESET(rst), .iS_DATA(s_data4), .iS_VALID(s_valid4), .oS_READY(s_ready4),
        .oWE(we4), .oADDR_WR(addr_wr4), .oDATA_WR(data_wr4), .oSTART(start4), .iDONE(done4),
        .oADDR_RD(addr_rd4), .iDATA_RD(data_rd4), .oM_DATA(m_data4), .oM_VALID(m_valid4),
        .iM_READY(m_ready4), .oM_LAST(m_last4), .oBUSY(busy4));

    fht_frame_mover #(.D_BIT(D_BIT), .ADC_WIDTH(ADC_W), .A_BIT(A8), .BANKS(B8),
                      .RD_LAT(RD_LAT), .REV_OUT(0)) u_dut8 (
        .iCLK(clk), .iRESET(rst), .iS_DATA(s_data8), .iS_VALID(s_valid8), .oS_READY(s_ready8),
        .oWE(we8), .oADDR_WR(addr_wr8), .oDATA_WR(data_wr8), .oSTART(start8), .iDONE(done8),
        .oADDR_RD(addr_rd8), .iDATA_RD(data_rd8), .oM_DATA(m_data8), .oM_VALID(m_valid8),
        .iM_READY(m_ready8), .oM_LAST(m_last8), .oBUSY(busy8));

    // RAM models: per-bank write on oWE, RD_LAT-stage registered read.
    logic [D_BIT-1:0]    mem4 [B4][R4];
    logic [D_BIT-1:0]    mem8 [B8][R8];
    logic [B4*D_BIT-1:0] pipe4 [RD_LAT];
    logic [B8*D_BIT-1:0] pipe8 [RD_LAT];

    always @(posedge clk) begin
        for (int b = 0; b < B4; b++) begin
            if (we4[b]) mem4[b][addr_wr4] <= data_wr4;
            pipe4[0][b*D_BIT +: D_BIT] <= mem4[b][addr_rd4];
        end
        for (int b = 0; b < B8; b++) begin
            if (we8[b]) mem8[b][addr_wr8] <= data_wr8;
            pipe8[0][b*D_BIT +: D_BIT] <= mem8[b][addr_rd8];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe4[i] <= pipe4[i-1];
            pipe8[i] <= pipe8[i-1];
        end
    end
    assign data_rd4 = pipe4[RD_LAT-1];
    assign data_rd8 = pipe8[RD_LAT-1];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   frame4 [N];
    int   frame8 [N];
    exp_t sb [$];
    int   rev_tab3 [R4] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp4();
        exp_t e;
        for (int i = 0; i < R4; i++) begin
            for (int b = 0; b < B4; b++) begin
                e.data = D_BIT'(frame4[rev_tab3[i]*B4 + b]) << (D_BIT - ADC_W);
                e.last = (i == R4-1) && (b == B4-1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid4 = 0; s_valid8 = 0; s_data4 = '0; s_data8 = '0;
        m_ready4 = 0; m_ready8 = 0; done4 = 1; done8 = 1;
        #12;
        n_tests++;
        if ({we4, addr_wr4, data_wr4, start4, addr_rd4, m_data4, m_valid4, m_last4, busy4, s_ready4} !== 58'd1) begin
            n_fail++;
            $display("FAIL reset4 got we=%b aw=%0d dw=%0h st=%b ar=%0d md=%0h mv=%b ml=%b busy=%b rdy=%b want all 0, rdy=1",
                     we4, addr_wr4, data_wr4, start4, addr_rd4, m_data4, m_valid4, m_last4, busy4, s_ready4);
        end
        n_tests++;
        if (we8 !== '0 || m_valid8 !== 1'b0 || m_data8 !== '0 || busy8 !== 1'b0 || s_ready8 !== 1'b1 || start8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8 got we=%b mv=%b md=%0h busy=%b rdy=%b st=%b", we8, m_valid8, m_data8, busy8, s_ready8, start8);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic load4();
        logic [B4-1:0]    ewe;
        logic [D_BIT-1:0] edata;
        s_valid4 = 1'b1;
        for (int k = 0; k < N; k++) begin
            s_data4 = ADC_W'(frame4[k]);
            n_tests++;
            if (s_ready4 !== 1'b1) begin n_fail++; $display("FAIL load_ready k=%0d got %b want 1", k, s_ready4); end
            tick();
            ewe   = B4'(1 << (k % B4));
            edata = D_BIT'(frame4[k]) << (D_BIT - ADC_W);
            n_tests++;
            if (we4 !== ewe || addr_wr4 !== A4'(k / B4) || data_wr4 !== edata || start4 !== 1'b0) begin
                n_fail++;
                $display("FAIL write k=%0d got we=%b aw=%0d dw=%0h st=%b want we=%b aw=%0d dw=%0h st=0",
                         k, we4, addr_wr4, data_wr4, start4, ewe, k / B4, edata);
            end
        end
        n_tests++;
        if (s_ready4 !== 1'b0 || busy4 !== 1'b1) begin
            n_fail++; $display("FAIL kick_ready got rdy=%b busy=%b want 0 1", s_ready4, busy4);
        end
        tick();
        n_tests++;
        if (start4 !== 1'b1 || we4 !== '0) begin
            n_fail++; $display("FAIL start_pulse got st=%b we=%b want 1 0000", start4, we4);
        end
        s_valid4 = 1'b0;
        tick();
        n_tests++;
        if (start4 !== 1'b0 || we4 !== '0) begin
            n_fail++; $display("FAIL start_once got st=%b we=%b want 0 0000", start4, we4);
        end
    endtask

    task automatic wait_done4();
        repeat (2) begin
            tick();
            n_tests++;
            if (m_valid4 !== 1'b0 || busy4 !== 1'b1) begin
                n_fail++; $display("FAIL stale_done got mv=%b busy=%b want 0 1", m_valid4, busy4);
            end
        end
        done4 = 1'b0;
        repeat (5) begin
            tick();
            n_tests++;
            if (m_valid4 !== 1'b0) begin n_fail++; $display("FAIL done_low got mv=%b want 0", m_valid4); end
        end
        done4 = 1'b1;
        for (int c = 1; c <= RD_LAT + 2; c++) begin
            tick();
            n_tests++;
            if (m_valid4 !== (c == RD_LAT + 2)) begin
                n_fail++; $display("FAIL fetch_latency c=%0d got mv=%b want %b", c, m_valid4, c == RD_LAT + 2);
            end
        end
    endtask

    task automatic drain4(input int duty, input int stop_words);
        int               words = 0, cyc = 0, last_rise = -1;
        logic             prev_valid = 0, hold = 0;
        logic [D_BIT-1:0] held;
        int               addrs [$];
        exp_t             e;
        while (words < N && cyc < 2000) begin
            if (m_valid4 && !prev_valid) begin
                addrs.push_back(int'(addr_rd4));
                if (last_rise >= 0 && duty == 100) begin
                    n_tests++;
                    if (cyc - last_rise != RD_LAT + 1 + B4) begin
                        n_fail++; $display("FAIL row_period got %0d want %0d", cyc - last_rise, RD_LAT + 1 + B4);
                    end
                end
                last_rise = cyc;
            end
            if (hold) begin
                n_tests++;
                if (m_valid4 !== 1'b1 || m_data4 !== held) begin
                    n_fail++; $display("FAIL stall_stable got mv=%b d=%0h want 1 %0h", m_valid4, m_data4, held);
                end
            end
            if (stop_words > 0 && words == stop_words && m_valid4) begin
                m_ready4 = 1'b0;
                return;
            end
            m_ready4 = ($urandom_range(0, 99) < duty);
            if (m_valid4 && m_ready4) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL sb_underflow word=%0d got %0h want nothing", words, m_data4);
                end else begin
                    e = sb.pop_front();
                    if (m_data4 !== e.data || m_last4 !== e.last) begin
                        n_fail++;
                        $display("FAIL word%0d got d=%0h last=%b want d=%0h last=%b", words, m_data4, m_last4, e.data, e.last);
                    end
                end
                words++;
            end
            hold       = m_valid4 && !m_ready4;
            held       = m_data4;
            prev_valid = m_valid4;
            tick();
            cyc++;
        end
        m_ready4 = 1'b0;
        n_tests++;
        if (cyc >= 2000) begin n_fail++; $display("FAIL drain_timeout got %0d words want %0d", words, N); end
        n_tests++;
        if (addrs.size() != R4) begin n_fail++; $display("FAIL row_count got %0d want %0d", addrs.size(), R4); end
        for (int i = 0; i < addrs.size() && i < R4; i++) begin
            n_tests++;
            if (addrs[i] != rev_tab3[i]) begin
                n_fail++; $display("FAIL addr_rd row%0d got %0d want %0d", i, addrs[i], rev_tab3[i]);
            end
        end
        n_tests++;
        if (busy4 !== 1'b0 || s_ready4 !== 1'b1 || m_valid4 !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_end got busy=%b rdy=%b mv=%b left=%0d want 0 1 0 0", busy4, s_ready4, m_valid4, sb.size());
        end
    endtask

    task automatic test_load_ramp();
        for (int k = 0; k < N; k++) frame4[k] = k;
        load4();
        wait_done4();
        push_exp4();
        drain4(100, 0);
    endtask

    task automatic test_drain_rev();
        for (int k = 0; k < N; k++) frame4[k] = 10 * (k / B4) + (k % B4);
        load4();
        wait_done4();
        push_exp4();
        drain4(100, 0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) frame4[k] = int'($urandom_range(0, 16383));
        load4();
        wait_done4();
        push_exp4();
        drain4(30, 0);
    endtask

    task automatic test_reset_mid_emit();
        for (int k = 0; k < N; k++) frame4[k] = 500 + k;
        load4();
        wait_done4();
        push_exp4();
        drain4(100, 3 * B4);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (m_valid4 !== 1'b0 || s_ready4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got mv=%b rdy=%b busy=%b want 0 1 0", m_valid4, s_ready4, busy4);
        end
        #2 rst = 1'b0;
        sb.delete();
        tick();
        for (int k = 0; k < N; k++) frame4[k] = 900 + 3 * k;
        load4();
        wait_done4();
        push_exp4();
        drain4(100, 0);
    endtask

    task automatic test_natural8();
        int               words = 0, cyc = 0;
        int               addrs [$];
        logic             prev_valid = 0;
        logic [D_BIT-1:0] edata;
        done8 = 1'b0;
        tick();
        done8 = 1'b1;
        tick();
        n_tests++;
        if (busy8 !== 1'b0 || s_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL done_in_load got busy=%b rdy=%b want 0 1", busy8, s_ready8);
        end
        s_valid8 = 1'b1;
        for (int k = 0; k < N; k++) begin
            frame8[k] = 100 + k;
            s_data8 = ADC_W'(frame8[k]);
            tick();
            n_tests++;
            if (we8 !== B8'(1 << (k % B8)) || addr_wr8 !== A8'(k / B8)) begin
                n_fail++; $display("FAIL write8 k=%0d got we=%b aw=%0d want bank %0d row %0d", k, we8, addr_wr8, k % B8, k / B8);
            end
        end
        s_valid8 = 1'b0;
        repeat (3) tick();
        done8 = 1'b0;
        repeat (2) tick();
        done8 = 1'b1;
        m_ready8 = 1'b1;
        while (words < N && cyc < 1000) begin
            if (m_valid8 && !prev_valid) addrs.push_back(int'(addr_rd8));
            if (m_valid8) begin
                edata = D_BIT'(frame8[words]) << (D_BIT - ADC_W);
                n_tests++;
                if (m_data8 !== edata || m_last8 !== (words == N - 1)) begin
                    n_fail++;
                    $display("FAIL word8_%0d got d=%0h last=%b want d=%0h last=%b", words, m_data8, m_last8, edata, words == N - 1);
                end
                words++;
            end
            prev_valid = m_valid8;
            tick();
            cyc++;
        end
        m_ready8 = 1'b0;
        n_tests++;
        if (cyc >= 1000) begin n_fail++; $display("FAIL drain8_timeout got %0d words want %0d", words, N); end
        n_tests++;
        if (addrs.size() != R8) begin n_fail++; $display("FAIL row_count8 got %0d want %0d", addrs.size(), R8); end
        for (int i = 0; i < addrs.size() && i < R8; i++) begin
            n_tests++;
            if (addrs[i] != i) begin n_fail++; $display("FAIL addr_rd8 row%0d got %0d want %0d", i, addrs[i], i); end
        end
        n_tests++;
        if (busy8 !== 1'b0 || m_valid8 !== 1'b0) begin
            n_fail++; $display("FAIL drain8_end got busy=%b mv=%b want 0 0", busy8, m_valid8);
        end
    endtask

    initial begin
        test_reset();
        test_load_ramp();
        test_drain_rev();
        test_backpressure();
        test_reset_mid_emit();
        test_natural8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
